periph_bus: RTL and testbench
=============================

# periph_bus

Memory-mapped peripheral responder for the pipelined MIPS core: the target side of the core's data-memory load/store interface for the I/O window. It decodes MEM-stage accesses in the 0x4000_00xx window and serves a reloadable timer with interrupt, a 16-bit LED register, a seven-segment digit register and a free-running SysTick counter. It sits beside the data RAM; the MEM-stage read mux selects this block's read data whenever `periph_sel` is high.

## Interface
- `BASE_ADDR`, 32'h4000_0000, window base; block decodes `Address[31:8] == BASE_ADDR[31:8]`
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately
- `Address`  in  32  MEM-stage byte address; `Address[1:0]` ignored
- `MemRead`  in  1  load strobe
- `MemWrite`  in  1  store strobe
- `Write_data`  in  32  store data
- `Read_data`  out  32  load data, combinational
- `periph_sel`  out  1  address in window (combinational, independent of strobes)
- `irq`  out  1  timer interrupt request, registered
- `led`  out  16  LED register
- `AN`  out  4  digit enables, active-low
- `BCD`  out  8  segment pattern, active-low

## Operation
- Register map (offset = `Address[7:0]`):
  - 0x00 TH, RW, 32-bit reload value.
  - 0x04 TL, RW, 32-bit count.
  - 0x08 TCON, RW [2:0]: bit0 EN, bit1 IE, bit2 ST (write-0-to-clear; writing 1 leaves ST unchanged). Bits 31:3 read 0.
  - 0x0C LED, RW [15:0].
  - 0x10 DIGITS, RW [11:0]: [11:8] → `AN`, [7:0] → `BCD`.
  - 0x14 SYSTICK, RO, 32-bit; writes ignored.
  - Other in-window offsets: read 0, writes ignored.
- Reads: `Read_data` = selected register when `periph_sel & MemRead`, else 0. Zero wait states.
- Writes: `periph_sel & MemWrite` updates register at next rising edge; upper unused bits discarded.
- MemRead and MemWrite together: write commits at edge; read that cycle returns the pre-write value.
- Timer, each edge with EN=1: if TL == 32'hFFFF_FFFF then TL ← TH and ST ← 1 if IE=1; else TL ← TL+1. EN=0 holds TL.
- `irq` = registered (IE & ST).
- SYSTICK increments every edge, wraps 32'hFFFF_FFFF → 0.
- Reset values: TH=0, TL=0, TCON=0, LED=0, DIGITS=12'hFFF (`AN`=4'hF, `BCD`=8'hFF, display dark), SYSTICK=0, `irq`=0.

## Timing
- Read latency 0 (same cycle); write latency 1 edge.
- Conflicts on one edge:
  - CPU write to TL beats timer increment/reload.
  - CPU write to TH with reload: reload uses old TH.
  - Overflow setting ST beats a CPU write clearing ST (interrupt never lost); IE/EN bits of that write still apply.
- `irq` asserts 1 edge after ST/IE both become 1; deasserts 1 edge after the clearing write.
- Reset assertion mid-count: all state cleared asynchronously, no edge required; counting resumes at first edge after `reset` returns high, SYSTICK reading N after N edges.

## Structure
- Shared package `periph_pkg`: offset constants (TH/TL/TCON/LED/DIGITS/SYSTICK), TCON bit indices (EN=0, IE=1, ST=2), DIGITS reset value 12'hFFF.
- One sub-module `periph_timer`: TH/TL/TCON plus overflow/reload/ST logic; write-enable inputs from the decoder. Decode, LED, DIGITS, SYSTICK and read mux in `periph_bus`.

## Test plan
- Reset: drive `reset`=0 mid-run → immediately `led`=0, `AN`=4'hF, `BCD`=8'hFF, `irq`=0, every register reads 0 (DIGITS reads 12'hFFF).
- Write TH=32'hFFFF_FFFE, TL=32'hFFFF_FFFE, TCON=3 → TL reads FFFF_FFFF after 1 edge, FFFF_FFFE after 2 with TCON=7; `irq`=1 one edge later.
- With ST set, write TCON=3 on a non-overflow edge → ST=0, `irq`=0 next edge; repeat on the exact overflow edge → ST stays 1.
- Write TL=5 on the edge where TL would reload → TL reads 5.
- SYSTICK: deassert reset, after 100 edges read 0x4000_0014 → 100; write 0 to it → value unaffected.
- Decode: read 0x4000_0018 → `periph_sel`=1, data 0; read 0x1001_0000 → `periph_sel`=0, data 0; write LED=32'h1234_ABCD → `led`=16'hABCD.

Source files
------------

// File: rtl/periph_pkg.sv
// Shared constants for the MIPS I/O-window peripheral responder:
// register offsets, TCON bit positions and the dark-display reset pattern.
package periph_pkg;

   localparam logic [7:0] OFF_TH      = 8'h00;
   localparam logic [7:0] OFF_TL      = 8'h04;
   localparam logic [7:0] OFF_TCON    = 8'h08;
   localparam logic [7:0] OFF_LED     = 8'h0C;
   localparam logic [7:0] OFF_DIGITS  = 8'h10;
   localparam logic [7:0] OFF_SYSTICK = 8'h14;

   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_ST = 2;

   localparam logic [11:0] DIGITS_RST = 12'hFFF;

   typedef enum logic [2:0] {
      REG_TH, REG_TL, REG_TCON, REG_LED, REG_DIGITS, REG_SYSTICK, REG_NONE
   } reg_sel_e;

   // Word index (byte offset [7:2]) to register; byte lanes are ignored.
   function automatic reg_sel_e decode_word(input logic [5:0] word);
      logic [7:0] off;
      off = {word, 2'b00};
      case (off)
         OFF_TH:      return REG_TH;
         OFF_TL:      return REG_TL;
         OFF_TCON:    return REG_TCON;
         OFF_LED:     return REG_LED;
         OFF_DIGITS:  return REG_DIGITS;
         OFF_SYSTICK: return REG_SYSTICK;
         default:     return REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/periph_bus_if.sv
// MEM-stage load/store bus between the core (master) and the peripheral
// responder (slave); read data and select are combinational from the slave.
interface periph_bus_if;
   logic [31:0] Address;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Write_data;
   logic [31:0] Read_data;
   logic        periph_sel;

   modport master (
      output Address, MemRead, MemWrite, Write_data,
      input  Read_data, periph_sel
   );

   modport slave (
      input  Address, MemRead, MemWrite, Write_data,
      output Read_data, periph_sel
   );
endinterface

// File: rtl/periph_timer.sv
// Reloadable up-counting timer: TH reload, TL count, TCON {ST,IE,EN},
// sticky overflow status and a registered interrupt request.
module periph_timer
   import periph_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        th_we_i,
   input  logic        tl_we_i,
   input  logic        tcon_we_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] th_o,
   output logic [31:0] tl_o,
   output logic [2:0]  tcon_o,
   output logic        irq_o
);

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic        en_q, en_d;
   logic        ie_q, ie_d;
   logic        st_q, st_d;
   logic        irq_q;
   logic        ovf;

   always_comb begin
      ovf  = en_q && (tl_q == 32'hFFFF_FFFF);
      th_d = th_we_i ? wdata_i : th_q;
      tl_d = tl_q;
      en_d = en_q;
      ie_d = ie_q;
      st_d = st_q;

      // A CPU write to TL wins; a reload always takes the pre-write TH.
      if (tl_we_i)
         tl_d = wdata_i;
      else if (ovf)
         tl_d = th_q;
      else if (en_q)
         tl_d = tl_q + 32'd1;

      if (tcon_we_i) begin
         en_d = wdata_i[TCON_EN];
         ie_d = wdata_i[TCON_IE];
         if (!wdata_i[TCON_ST])
            st_d = 1'b0;
      end
      // Overflow is applied last so a same-edge clear can never lose it.
      if (ovf && ie_q)
         st_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th_q  <= '0;
         tl_q  <= '0;
         en_q  <= 1'b0;
         ie_q  <= 1'b0;
         st_q  <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         th_q  <= th_d;
         tl_q  <= tl_d;
         en_q  <= en_d;
         ie_q  <= ie_d;
         st_q  <= st_d;
         irq_q <= ie_q & st_q;
      end
   end

   assign th_o   = th_q;
   assign tl_o   = tl_q;
   assign tcon_o = {st_q, ie_q, en_q};
   assign irq_o  = irq_q;

endmodule

// File: rtl/periph_bus.sv
// Peripheral responder for the 0x4000_00xx I/O window: address decode,
// LED/DIGITS/SYSTICK registers, timer instance and zero-wait read mux.
module periph_bus
   import periph_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
   input  logic         clk,
   input  logic         reset,
   periph_bus_if.slave  bus,
   output logic         irq,
   output logic [15:0]  led,
   output logic [3:0]   AN,
   output logic [7:0]   BCD
);

   logic        sel;
   logic        wr;
   reg_sel_e    reg_sel;
   logic [31:0] rdata;

   logic [15:0] led_q, led_d;
   logic [11:0] digits_q, digits_d;
   logic [31:0] systick_q, systick_d;

   logic [31:0] th, tl;
   logic [2:0]  tcon;

   assign sel     = (bus.Address[31:8] == BASE_ADDR[31:8]);
   assign wr      = sel && bus.MemWrite;
   assign reg_sel = decode_word(bus.Address[7:2]);

   periph_timer u_timer (
      .clk       (clk),
      .reset     (reset),
      .th_we_i   (wr && (reg_sel == REG_TH)),
      .tl_we_i   (wr && (reg_sel == REG_TL)),
      .tcon_we_i (wr && (reg_sel == REG_TCON)),
      .wdata_i   (bus.Write_data),
      .th_o      (th),
      .tl_o      (tl),
      .tcon_o    (tcon),
      .irq_o     (irq)
   );

   always_comb begin
      led_d     = led_q;
      digits_d  = digits_q;
      systick_d = systick_q + 32'd1;
      if (wr && (reg_sel == REG_LED))
         led_d = bus.Write_data[15:0];
      if (wr && (reg_sel == REG_DIGITS))
         digits_d = bus.Write_data[11:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_q     <= '0;
         digits_q  <= DIGITS_RST;
         systick_q <= '0;
      end else begin
         led_q     <= led_d;
         digits_q  <= digits_d;
         systick_q <= systick_d;
      end
   end

   // Reads always see the pre-edge register state, even alongside a write.
   always_comb begin
      rdata = '0;
      if (sel && bus.MemRead) begin
         case (reg_sel)
            REG_TH:      rdata = th;
            REG_TL:      rdata = tl;
            REG_TCON:    rdata = {29'd0, tcon};
            REG_LED:     rdata = {16'd0, led_q};
            REG_DIGITS:  rdata = {20'd0, digits_q};
            REG_SYSTICK: rdata = systick_q;
            default:     rdata = '0;
         endcase
      end
   end

   assign bus.Read_data  = rdata;
   assign bus.periph_sel = sel;
   assign led            = led_q;
   assign AN             = digits_q[11:8];
   assign BCD            = digits_q[7:0];

endmodule

// File: tb/tb_periph_bus.sv
// Scoreboard bench for periph_bus: expected values are queued as stimulus
// is applied and compared when the DUT output is sampled.
module tb_periph_bus;
   import periph_pkg::*;

   localparam logic [31:0] A_TH      = 32'h4000_0000;
   localparam logic [31:0] A_TL      = 32'h4000_0004;
   localparam logic [31:0] A_TCON    = 32'h4000_0008;
   localparam logic [31:0] A_LED     = 32'h4000_000C;
   localparam logic [31:0] A_DIGITS  = 32'h4000_0010;
   localparam logic [31:0] A_SYSTICK = 32'h4000_0014;

   logic        clk = 1'b0;
   logic        reset;
   logic        irq;
   logic [15:0] led;
   logic [3:0]  AN;
   logic [7:0]  BCD;

   periph_bus_if bus_if();

   periph_bus #(.BASE_ADDR(32'h4000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if),
      .irq   (irq),
      .led   (led),
      .AN    (AN),
      .BCD   (BCD)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;

   sb_t         sb_q[$];
   logic [31:0] obs_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic push_exp(input string name, input logic [31:0] exp);
      sb_t e;
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   task automatic observe(input string name, input logic [31:0] got, input logic [31:0] exp);
      push_exp(name, exp);
      obs_q.push_back(got);
   endtask

   task automatic bus_rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
      push_exp(name, exp);
      bus_if.Address = addr;
      bus_if.MemRead = 1'b1;
      #1;
      obs_q.push_back(bus_if.Read_data);
      bus_if.MemRead = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus_if.Address    = addr;
      bus_if.Write_data = data;
      bus_if.MemWrite   = 1'b1;
      @(posedge clk);
      #1;
      bus_if.MemWrite   = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_timer;
      sb_t e;
      logic [31:0] g;
      wr(A_TH, 32'hFFFF_FFFE);
      wr(A_TL, 32'hFFFF_FFFE);
      wr(A_TCON, 32'd3);
      bus_rd("tl_start", A_TL, 32'hFFFF_FFFE);
      tick(1);
      bus_rd("tl_max", A_TL, 32'hFFFF_FFFF);
      tick(1);
      bus_rd("tl_reload", A_TL, 32'hFFFF_FFFE);
      bus_rd("tcon_st_set", A_TCON, 32'd7);
      observe("irq_not_yet", {31'd0, irq}, 32'd0);
      tick(1);
      observe("irq_asserted", {31'd0, irq}, 32'd1);
      wr(A_TL, 32'd5);
      bus_rd("tl_write_beats_reload", A_TL, 32'd5);
      bus_rd("tcon_st_kept", A_TCON, 32'd7);
      wr(A_TCON, 32'd3);
      bus_rd("tcon_st_cleared", A_TCON, 32'd3);
      observe("irq_lag", {31'd0, irq}, 32'd1);
      tick(1);
      observe("irq_deasserted", {31'd0, irq}, 32'd0);
      wr(A_TL, 32'hFFFF_FFFF);
      wr(A_TCON, 32'd3);
      bus_rd("tcon_ovf_beats_clear", A_TCON, 32'd7);
      wr(A_TL, 32'hFFFF_FFFF);
      wr(A_TH, 32'h0000_0100);
      bus_rd("tl_reload_old_th", A_TL, 32'hFFFF_FFFE);
      bus_rd("th_new", A_TH, 32'h0000_0100);
      tick(1);
      observe("irq_reasserted", {31'd0, irq}, 32'd1);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         g = obs_q.pop_front();
         n_cmp++;
         if (g !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, g, e.exp);
         end
      end
   endtask

   task automatic test_decode;
      sb_t e;
      logic [31:0] g;
      push_exp("sel_unmapped", 32'd1);
      bus_if.Address = 32'h4000_0018;
      #1;
      obs_q.push_back({31'd0, bus_if.periph_sel});
      bus_rd("rd_unmapped", 32'h4000_0018, 32'd0);
      push_exp("sel_outside", 32'd0);
      bus_if.Address = 32'h1001_0000;
      #1;
      obs_q.push_back({31'd0, bus_if.periph_sel});
      bus_rd("rd_outside", 32'h1001_0000, 32'd0);
      wr(A_LED, 32'h1234_ABCD);
      observe("led_out", {16'd0, led}, 32'h0000_ABCD);
      bus_rd("led_rd", A_LED, 32'h0000_ABCD);
      push_exp("rd_no_strobe", 32'd0);
      bus_if.Address = A_LED;
      #1;
      obs_q.push_back(bus_if.Read_data);
      wr(32'h1001_000C, 32'hFFFF_0000);
      observe("led_outside_write", {16'd0, led}, 32'h0000_ABCD);
      wr(A_DIGITS, 32'hFFFF_F5A3);
      observe("an_out", {28'd0, AN}, 32'h5);
      observe("bcd_out", {24'd0, BCD}, 32'hA3);
      bus_rd("digits_rd", A_DIGITS, 32'h0000_05A3);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         g = obs_q.pop_front();
         n_cmp++;
         if (g !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, g, e.exp);
         end
      end
   endtask

   task automatic test_reset;
      sb_t e;
      logic [31:0] g;
      #2;
      reset = 1'b0;
      #1;
      observe("rst_led", {16'd0, led}, 32'd0);
      observe("rst_an", {28'd0, AN}, 32'hF);
      observe("rst_bcd", {24'd0, BCD}, 32'hFF);
      observe("rst_irq", {31'd0, irq}, 32'd0);
      bus_rd("rst_th", A_TH, 32'd0);
      bus_rd("rst_tl", A_TL, 32'd0);
      bus_rd("rst_tcon", A_TCON, 32'd0);
      bus_rd("rst_digits", A_DIGITS, 32'h0000_0FFF);
      bus_rd("rst_systick", A_SYSTICK, 32'd0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         g = obs_q.pop_front();
         n_cmp++;
         if (g !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, g, e.exp);
         end
      end
   endtask

   task automatic test_systick;
      sb_t e;
      logic [31:0] g;
      @(negedge clk);
      reset = 1'b1;
      tick(100);
      bus_rd("systick_100", A_SYSTICK, 32'd100);
      wr(A_SYSTICK, 32'd0);
      bus_rd("systick_ro", A_SYSTICK, 32'd101);
      bus_rd("tl_held_after_reset", A_TL, 32'd0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         g = obs_q.pop_front();
         n_cmp++;
         if (g !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, g, e.exp);
         end
      end
   endtask

   task automatic test_back_to_back;
      sb_t e;
      logic [31:0] g;
      wr(A_LED, 32'h0000_1111);
      wr(A_DIGITS, 32'h0000_0E21);
      observe("b2b_led", {16'd0, led}, 32'h1111);
      observe("b2b_an", {28'd0, AN}, 32'hE);
      @(negedge clk);
      bus_if.Address    = A_LED;
      bus_if.Write_data = 32'h0000_55AA;
      bus_if.MemRead    = 1'b1;
      bus_if.MemWrite   = 1'b1;
      push_exp("rw_old_value", 32'h0000_1111);
      #1;
      obs_q.push_back(bus_if.Read_data);
      @(posedge clk);
      #1;
      bus_if.MemWrite = 1'b0;
      observe("rw_led_committed", {16'd0, led}, 32'h55AA);
      observe("rw_new_value", bus_if.Read_data, 32'h0000_55AA);
      bus_if.MemRead = 1'b0;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         g = obs_q.pop_front();
         n_cmp++;
         if (g !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, g, e.exp);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset             = 1'b0;
      bus_if.Address    = '0;
      bus_if.MemRead    = 1'b0;
      bus_if.MemWrite   = 1'b0;
      bus_if.Write_data = '0;
      #23;
      reset = 1'b1;
      test_timer();
      test_decode();
      test_reset();
      test_systick();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
